i2s_receiver: RTL and testbench

- Deserialises the one-bit I2S stream (word select plus serial data) into parallel left/right PCM samples.
- Sits directly downstream of the I2S transmitter, clocked by the same serial clock, and feeds the audio processing datapath.
- Outputs a coherent left/right pair with a one-cycle valid strobe per complete frame.
- Flags malformed slots.

---
 rtl/audio_pkg.sv | 17 +
 rtl/i2s_receiver.sv | 102 ++++++++++
 tb/tb_i2s_receiver.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions used by the I2S transmitter and receiver.
package audio_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    CAPTURE = 2'd1,
    SKIP    = 2'd2
  } i2s_rx_state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } i2s_channel_t;

endpackage

// File: rtl/i2s_receiver.sv
// I2S deserialiser: captures MSB-first slots one bit after each WS transition
// and presents coherent left/right pairs with a one-cycle valid strobe.
//
// state   | meaning
// SYNC    | after reset, waiting for the first WS transition
// CAPTURE | shifting in bits of the current slot
// SKIP    | word complete, ignoring padding until the next WS transition
module i2s_receiver
  import audio_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
) (
  input  logic             s_clk,
  input  logic             reset,
  input  logic             word_select,
  input  logic             sound_bit_in,
  output logic [WIDTH-1:0] left_sample,
  output logic [WIDTH-1:0] right_sample,
  output logic             sample_valid,
  output logic             framing_error
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  i2s_rx_state_t   state;
  i2s_channel_t    chan;
  logic            ws_q;
  logic            left_ok;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] left_hold;

  logic             ws_edge;
  logic             word_done;
  logic [WIDTH-1:0] word;

  assign ws_edge   = (word_select != ws_q);
  assign word      = {shift[WIDTH-2:0], sound_bit_in};
  // A WS transition at count == WIDTH-1 still delivers the LSB on this edge.
  assign word_done = (state == CAPTURE) && (count == LAST);

  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      state         <= SYNC;
      chan          <= LEFT;
      ws_q          <= 1'b0;
      left_ok       <= 1'b0;
      count         <= '0;
      shift         <= '0;
      left_hold     <= '0;
      left_sample   <= '0;
      right_sample  <= '0;
      sample_valid  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      ws_q          <= word_select;
      sample_valid  <= 1'b0;
      framing_error <= 1'b0;

      if (word_done) begin
        if (chan == LEFT) begin
          left_hold <= word;
          left_ok   <= 1'b1;
        end else if (left_ok) begin
          left_sample  <= left_hold;
          right_sample <= word;
          sample_valid <= 1'b1;
          left_ok      <= 1'b0;
        end
      end

      case (state)
        SYNC, SKIP: begin
          if (ws_edge) begin
            state <= CAPTURE;
            count <= '0;
            chan  <= i2s_channel_t'(word_select);
          end
        end
        CAPTURE: begin
          if (ws_edge) begin
            if (count != LAST) begin
              framing_error <= 1'b1;
              left_ok       <= 1'b0;
            end
            count <= '0;
            chan  <= i2s_channel_t'(word_select);
          end else if (word_done) begin
            state <= SKIP;
            count <= count + CW'(1);
          end else begin
            shift <= word;
            count <= count + CW'(1);
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: directed frame table, random slot
// streams against a slot-level reference model, and reset corner cases.
module tb_i2s_receiver;
  import audio_pkg::*;

  localparam int W    = SAMPLE_W;
  localparam int MAXC = 2048;

  typedef struct {
    bit             chan;
    int             len;
    logic [W-1:0]   word;
    int             t0;
  } slot_t;

  typedef struct {
    int           len_l;
    int           len_r;
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           pad;
    int           n_valid;
    int           n_err;
    logic [W-1:0] exp_l;
    logic [W-1:0] exp_r;
  } frame_t;

  logic         s_clk = 1'b0;
  logic         reset = 1'b0;
  logic         word_select = 1'b0;
  logic         sound_bit_in = 1'b0;
  logic [W-1:0] left_sample;
  logic [W-1:0] right_sample;
  logic         sample_valid;
  logic         framing_error;

  i2s_receiver #(.WIDTH(W)) dut (
    .s_clk         (s_clk),
    .reset         (reset),
    .word_select   (word_select),
    .sound_bit_in  (sound_bit_in),
    .left_sample   (left_sample),
    .right_sample  (right_sample),
    .sample_valid  (sample_valid),
    .framing_error (framing_error)
  );

  always #5 s_clk = ~s_clk;

  int compared   = 0;
  int mismatched = 0;

  slot_t            slots[$];
  bit               ws_a[MAXC];
  bit               dat_a[MAXC];
  int               n_len;
  logic [2*W+1:0]   obs[MAXC];
  logic [2*W+1:0]   expv[MAXC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic clear_stream();
    slots.delete();
    n_len = 0;
  endtask

  // Bits are laid out aligned to WS; playback delays data by one clock (I2S).
  task automatic add_slot(input bit chan, input int len, input logic [W-1:0] word, input int pad);
    slot_t s;
    s.chan = chan;
    s.len  = len;
    s.word = word;
    s.t0   = n_len;
    slots.push_back(s);
    for (int i = 0; i < len; i++) begin
      ws_a[n_len] = chan;
      if (i < W) dat_a[n_len] = word[W-1-i];
      else if (pad == 2) dat_a[n_len] = 1'($urandom_range(0, 1));
      else dat_a[n_len] = (pad == 1);
      n_len++;
    end
  endtask

  // Slot-level reference: a slot opened by a WS transition yields a word after
  // W bits, or a framing error if the next transition comes first.
  task automatic run_model(input int ncyc);
    bit           ok = 1'b0;
    logic [W-1:0] hold = '0, cl = '0, cr = '0;
    bit           ev_v[MAXC];
    bit           ev_e[MAXC];
    logic [W-1:0] ev_l[MAXC];
    logic [W-1:0] ev_r[MAXC];
    bit           captured;
    int           t;
    for (int n = 0; n < ncyc; n++) begin
      ev_v[n] = 1'b0;
      ev_e[n] = 1'b0;
      ev_l[n] = '0;
      ev_r[n] = '0;
    end
    for (int k = 0; k < slots.size(); k++) begin
      captured = (k == 0) ? (slots[k].chan == 1'b1) : (slots[k].chan != slots[k-1].chan);
      if (!captured) continue;
      if (slots[k].len >= W) begin
        t = slots[k].t0 + W;
        if (slots[k].chan == 1'b0) begin
          hold = slots[k].word;
          ok   = 1'b1;
        end else if (ok) begin
          if (t < ncyc) begin
            ev_v[t] = 1'b1;
            ev_l[t] = hold;
            ev_r[t] = slots[k].word;
          end
          ok = 1'b0;
        end
      end else if (k < slots.size() - 1) begin
        t = slots[k].t0 + slots[k].len;
        if (t < ncyc) ev_e[t] = 1'b1;
        ok = 1'b0;
      end
    end
    for (int n = 0; n < ncyc; n++) begin
      if (ev_v[n]) begin
        cl = ev_l[n];
        cr = ev_r[n];
      end
      expv[n] = {ev_v[n], ev_e[n], cl, cr};
    end
  endtask

  task automatic play(input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      word_select  = ws_a[n];
      sound_bit_in = (n == 0) ? 1'b0 : dat_a[n-1];
      @(posedge s_clk);
      #1;
      obs[n] = {sample_valid, framing_error, left_sample, right_sample};
      @(negedge s_clk);
    end
    for (int n = 0; n < ncyc; n++)
      check($sformatf("cycle%0d {valid,err,left,right}", n), 64'(obs[n]), 64'(expv[n]));
  endtask

  function automatic int count_bit(input int from, input int upto, input int b);
    int c = 0;
    for (int n = from; n <= upto; n++) c += int'(obs[n][b]);
    return c;
  endfunction

  initial begin
    frame_t tbl[6];
    int     fl[6];
    int     fr[6];
    int     vc[3];
    int     endc;
    int     len;
    int     ncut;

    tbl[0] = '{12, 12, 12'hA5C, 12'h3F1, 0, 1, 0, 12'hA5C, 12'h3F1};
    tbl[1] = '{12, 12, 12'hA5C, 12'h3F1, 0, 1, 0, 12'hA5C, 12'h3F1};
    tbl[2] = '{12, 12, 12'hA5C, 12'h3F1, 0, 1, 0, 12'hA5C, 12'h3F1};
    tbl[3] = '{16, 16, 12'h800, 12'h7FF, 1, 1, 0, 12'h800, 12'h7FF};
    tbl[4] = '{ 8, 12, 12'h9C6, 12'h123, 0, 0, 1, 12'h800, 12'h7FF};
    tbl[5] = '{12, 12, 12'h001, 12'h002, 0, 1, 0, 12'h001, 12'h002};

    #12;
    check("reset_outputs", 64'({sample_valid, framing_error, left_sample, right_sample}), 64'd0);

    // Stream 1: right-slot start, directed frames, then random slots.
    clear_stream();
    add_slot(1'b1, 14, 12'($urandom), 2);
    for (int f = 0; f < 6; f++) begin
      fl[f] = n_len;
      add_slot(1'b0, tbl[f].len_l, tbl[f].l, tbl[f].pad);
      fr[f] = n_len;
      add_slot(1'b1, tbl[f].len_r, tbl[f].r, tbl[f].pad);
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) len = $urandom_range(3, W - 1);
      else len = $urandom_range(W, W + 5);
      add_slot(bit'(i % 2), len, 12'($urandom), 2);
    end
    add_slot(1'b0, 3, '0, 0);

    @(negedge s_clk);
    reset = 1'b1;
    run_model(n_len);
    play(n_len);

    check("right_first_discarded", 64'(count_bit(0, fl[0], 2*W+1)), 64'd0);
    for (int f = 0; f < 6; f++) begin
      endc = fr[f] + tbl[f].len_r;
      check($sformatf("frame%0d_valid_count", f), 64'(count_bit(fl[f] + 1, endc, 2*W+1)),
            64'(tbl[f].n_valid));
      check($sformatf("frame%0d_error_count", f), 64'(count_bit(fl[f] + 1, endc, 2*W)),
            64'(tbl[f].n_err));
      check($sformatf("frame%0d_outputs", f), 64'(obs[endc][2*W-1:0]),
            64'({tbl[f].exp_l, tbl[f].exp_r}));
    end
    for (int f = 0; f < 3; f++) begin
      vc[f] = -1;
      for (int n = fl[f] + 1; n <= fr[f] + tbl[f].len_r; n++)
        if (obs[n][2*W+1]) vc[f] = n;
    end
    check("packed_spacing_0_1", 64'(vc[1] - vc[0]), 64'd24);
    check("packed_spacing_1_2", 64'(vc[2] - vc[1]), 64'd24);

    // Stream 2: reset asserted in the middle of a right slot.
    reset = 1'b0;
    word_select = 1'b0;
    @(negedge s_clk);
    clear_stream();
    add_slot(1'b1, 14, 12'($urandom), 2);
    add_slot(1'b0, 12, 12'h3C3, 0);
    add_slot(1'b1, 12, 12'h5A5, 0);
    add_slot(1'b0, 12, 12'h111, 0);
    add_slot(1'b1, 20, 12'h222, 0);
    ncut = slots[4].t0 + 5;
    reset = 1'b1;
    run_model(ncut);
    play(ncut);
    check("pre_reset_outputs", 64'({left_sample, right_sample}), 64'({12'h3C3, 12'h5A5}));
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", 64'({sample_valid, framing_error, left_sample, right_sample}), 64'd0);
    word_select = 1'b1;
    @(negedge s_clk);
    @(negedge s_clk);

    // Stream 3: release while WS is still high, then a full frame.
    clear_stream();
    add_slot(1'b1, 7, 12'($urandom), 2);
    add_slot(1'b0, 12, 12'hFFF, 0);
    add_slot(1'b1, 12, 12'h000, 0);
    add_slot(1'b0, 3, '0, 0);
    reset = 1'b1;
    run_model(n_len);
    play(n_len);
    check("post_reset_valid_count", 64'(count_bit(0, n_len - 1, 2*W+1)), 64'd1);
    check("post_reset_outputs", 64'(obs[n_len-1][2*W-1:0]), 64'({12'hFFF, 12'h000}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
